// File: rtl/ttt_engine_nxk_if.sv
// Move handshake between the move-input logic and the tic-tac-toe engine.
interface ttt_engine_nxk_if #(
    parameter int IW = 2
);
    logic          move_valid;
    logic [IW-1:0] move_row;
    logic [IW-1:0] move_col;
    logic          move_ready;
    logic          move_accept;
    logic          move_reject;

    modport master (
        output move_valid, move_row, move_col,
        input  move_ready, move_accept, move_reject
    );

    modport slave (
        input  move_valid, move_row, move_col,
        output move_ready, move_accept, move_reject
    );
endinterface

// File: rtl/ttt_engine_nxk.sv
// N x N, K-in-a-row tic-tac-toe engine: move legality, board state,
// move counter and a one-cycle registered win/draw check.
module ttt_engine_nxk #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int IW = (N <= 2) ? 1 : $clog2(N),
    parameter int CW = $clog2(N*N+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_game,
    ttt_engine_nxk_if.slave       mv,
    output logic                  turn,
    output logic [N*N-1:0]        board_p1,
    output logic [N*N-1:0]        board_p2,
    output logic [CW-1:0]         move_count,
    output logic                  win_p1,
    output logic                  win_p2,
    output logic                  draw,
    output logic                  game_over
);
    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;

    logic [1:0]     state;
    logic           last_p2;
    logic           accept_q;
    logic           reject_q;
    logic [N*N-1:0] hit;
    logic [N*N-1:0] mb;
    logic [N*N-1:0] hit_h, hit_v, hit_d, hit_a;
    logic           legal;
    logic           any_win;

    // Bitmask of K cells starting at (r0,c0) stepping by (dr,dc).
    function automatic logic [N*N-1:0] line_mask(int r0, int c0, int dr, int dc);
        logic [N*N-1:0] m;
        int idx;
        m = '0;
        for (int unsigned i = 0; i < K; i++) begin
            idx = (r0 + dr*int'(i))*N + c0 + dc*int'(i);
            m = m | ({{(N*N-1){1'b0}}, 1'b1} << idx);
        end
        return m;
    endfunction

    // Only the last mover can have just completed a line.
    assign mb = last_p2 ? board_p2 : board_p1;

    for (genvar r = 0; r < N; r++) begin : g_r
        for (genvar c = 0; c < N; c++) begin : g_c
            assign hit[r*N+c] = (mv.move_row == IW'(r)) && (mv.move_col == IW'(c));
            if (c + K <= N) begin : g_h
                localparam logic [N*N-1:0] M = line_mask(r, c, 0, 1);
                assign hit_h[r*N+c] = (mb & M) == M;
            end else begin : g_hn
                assign hit_h[r*N+c] = 1'b0;
            end
            if (r + K <= N) begin : g_v
                localparam logic [N*N-1:0] M = line_mask(r, c, 1, 0);
                assign hit_v[r*N+c] = (mb & M) == M;
            end else begin : g_vn
                assign hit_v[r*N+c] = 1'b0;
            end
            if (r + K <= N && c + K <= N) begin : g_d
                localparam logic [N*N-1:0] M = line_mask(r, c, 1, 1);
                assign hit_d[r*N+c] = (mb & M) == M;
            end else begin : g_dn
                assign hit_d[r*N+c] = 1'b0;
            end
            if (r + K <= N && c >= K - 1) begin : g_a
                localparam logic [N*N-1:0] M = line_mask(r, c, 1, -1);
                assign hit_a[r*N+c] = (mb & M) == M;
            end else begin : g_an
                assign hit_a[r*N+c] = 1'b0;
            end
        end
    end

    // An out-of-range index matches no cell, so hit is all-zero for it.
    assign legal   = (|hit) && !(|(hit & (board_p1 | board_p2)));
    assign any_win = |{hit_h, hit_v, hit_d, hit_a};

    assign mv.move_ready  = (state == S_WAIT);
    assign mv.move_accept = accept_q;
    assign mv.move_reject = reject_q;
    assign game_over      = win_p1 | win_p2 | draw;

    // Game FSM: accept/reject moves, then register the win/draw result.
    always_ff @(posedge clk) begin
        if (!rst || new_game) begin
            state      <= S_WAIT;
            turn       <= 1'b0;
            last_p2    <= 1'b0;
            board_p1   <= '0;
            board_p2   <= '0;
            move_count <= '0;
            win_p1     <= 1'b0;
            win_p2     <= 1'b0;
            draw       <= 1'b0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (mv.move_valid) begin
                        if (legal) begin
                            if (turn) board_p2 <= board_p2 | hit;
                            else      board_p1 <= board_p1 | hit;
                            accept_q   <= 1'b1;
                            move_count <= move_count + CW'(1);
                            turn       <= ~turn;
                            last_p2    <= turn;
                            state      <= S_CHECK;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (any_win) begin
                        if (last_p2) win_p2 <= 1'b1;
                        else         win_p1 <= 1'b1;
                        state <= S_OVER;
                    end else if (move_count == CW'(N*N)) begin
                        draw  <= 1'b1;
                        state <= S_OVER;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_OVER:  state <= S_OVER;
                default: state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ttt_engine_nxk.sv
// Self-checking bench: a 3x3/K=3 engine and a 5x5/K=4 engine.
module tb_ttt_engine_nxk;
    logic clk;
    logic rst;
    logic new_game;

    ttt_engine_nxk_if #(.IW(2)) ifa ();
    ttt_engine_nxk_if #(.IW(3)) ifb ();

    logic        turn_a, wa1, wa2, da, goa;
    logic [8:0]  bp1a, bp2a;
    logic [3:0]  cnta;
    logic        turn_b, wb1, wb2, db, gob;
    logic [24:0] bp1b, bp2b;
    logic [4:0]  cntb;

    ttt_engine_nxk #(.N(3), .K(3), .IW(2), .CW(4)) dut_a (
        .clk(clk), .rst(rst), .new_game(new_game), .mv(ifa.slave),
        .turn(turn_a), .board_p1(bp1a), .board_p2(bp2a), .move_count(cnta),
        .win_p1(wa1), .win_p2(wa2), .draw(da), .game_over(goa)
    );

    ttt_engine_nxk #(.N(5), .K(4), .IW(3), .CW(5)) dut_b (
        .clk(clk), .rst(rst), .new_game(new_game), .mv(ifb.slave),
        .turn(turn_b), .board_p1(bp1b), .board_p2(bp2b), .move_count(cntb),
        .win_p1(wb1), .win_p2(wb2), .draw(db), .game_over(gob)
    );

    localparam logic [1:0] ACC  = 2'b10;
    localparam logic [1:0] REJ  = 2'b01;
    localparam logic [1:0] NONE = 2'b00;

    typedef struct {
        int         d;
        int         r;
        int         c;
        logic [1:0] exp;
    } mv_t;

    mv_t        tbl [0:41];
    logic [1:0] sbq [$];
    int         tests;
    int         failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] acc_rej(input int d);
        return (d == 0) ? {ifa.move_accept, ifa.move_reject} : {ifb.move_accept, ifb.move_reject};
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? ifa.move_ready : ifb.move_ready;
    endfunction

    task automatic drive(input int d, input logic v, input int r, input int c);
        if (d == 0) begin
            ifa.move_valid = v; ifa.move_row = 2'(r); ifa.move_col = 2'(c);
        end else begin
            ifb.move_valid = v; ifb.move_row = 3'(r); ifb.move_col = 3'(c);
        end
    endtask

    task automatic check_state(input string tag, input int d,
                               input logic [31:0] p1, input logic [31:0] p2, input int cnt,
                               input logic t, input logic w1, input logic w2,
                               input logic dr, input logic rdy);
        if (d == 0) begin
            check({tag, "_p1"}, 32'(bp1a), p1);
            check({tag, "_p2"}, 32'(bp2a), p2);
            check({tag, "_cnt"}, 32'(cnta), 32'(cnt));
            check({tag, "_turn"}, 32'(turn_a), 32'(t));
            check({tag, "_win"}, {30'd0, wa1, wa2}, {30'd0, w1, w2});
            check({tag, "_draw"}, 32'(da), 32'(dr));
            check({tag, "_over"}, 32'(goa), 32'(w1 | w2 | dr));
        end else begin
            check({tag, "_p1"}, 32'(bp1b), p1);
            check({tag, "_p2"}, 32'(bp2b), p2);
            check({tag, "_cnt"}, 32'(cntb), 32'(cnt));
            check({tag, "_turn"}, 32'(turn_b), 32'(t));
            check({tag, "_win"}, {30'd0, wb1, wb2}, {30'd0, w1, w2});
            check({tag, "_draw"}, 32'(db), 32'(dr));
            check({tag, "_over"}, 32'(gob), 32'(w1 | w2 | dr));
        end
        check({tag, "_ready"}, 32'(get_ready(d)), 32'(rdy));
    endtask

    // One table move: wait for ready (bounded), strobe it, score the pulse.
    task automatic apply(input mv_t m);
        int unsigned n;
        n = 0;
        if (m.exp != NONE) begin
            while (!get_ready(m.d) && n < 20) begin
                step();
                n++;
            end
            if (!get_ready(m.d)) begin
                tests++;
                failed++;
                $display("FAIL ready_timeout actual=0 required=1 move=(%0d,%0d)", m.r, m.c);
            end
        end
        drive(m.d, 1'b1, m.r, m.c);
        sbq.push_back(m.exp);
        step();
        check($sformatf("move_d%0d_%0d_%0d", m.d, m.r, m.c), 32'(acc_rej(m.d)), 32'(sbq.pop_front()));
        drive(m.d, 1'b0, 0, 0);
        if (m.exp != NONE) begin
            sbq.push_back(NONE);
            step();
            check($sformatf("pulse_clear_d%0d_%0d_%0d", m.d, m.r, m.c), 32'(acc_rej(m.d)), 32'(sbq.pop_front()));
        end
    endtask

    task automatic play(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(tbl[i]);
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        // 3x3 P1 row win, then an ignored move
        tbl[0]  = '{0, 0, 0, ACC}; tbl[1]  = '{0, 1, 0, ACC}; tbl[2]  = '{0, 0, 1, ACC};
        tbl[3]  = '{0, 1, 1, ACC}; tbl[4]  = '{0, 0, 2, ACC}; tbl[5]  = '{0, 2, 2, NONE};
        // occupied cell and out-of-range row
        tbl[6]  = '{0, 0, 0, ACC}; tbl[7]  = '{0, 0, 0, REJ}; tbl[8]  = '{0, 3, 0, REJ};
        // full-board draw
        tbl[9]  = '{0, 0, 0, ACC}; tbl[10] = '{0, 0, 1, ACC}; tbl[11] = '{0, 0, 2, ACC};
        tbl[12] = '{0, 1, 1, ACC}; tbl[13] = '{0, 1, 0, ACC}; tbl[14] = '{0, 1, 2, ACC};
        tbl[15] = '{0, 2, 1, ACC}; tbl[16] = '{0, 2, 0, ACC}; tbl[17] = '{0, 2, 2, ACC};
        // win on the ninth (final) cell
        tbl[18] = '{0, 0, 0, ACC}; tbl[19] = '{0, 1, 0, ACC}; tbl[20] = '{0, 0, 1, ACC};
        tbl[21] = '{0, 1, 1, ACC}; tbl[22] = '{0, 1, 2, ACC}; tbl[23] = '{0, 2, 1, ACC};
        tbl[24] = '{0, 2, 0, ACC}; tbl[25] = '{0, 2, 2, ACC}; tbl[26] = '{0, 0, 2, ACC};
        // 5x5 K=4 diagonal for P1
        tbl[27] = '{1, 1, 1, ACC}; tbl[28] = '{1, 0, 1, ACC}; tbl[29] = '{1, 2, 2, ACC};
        tbl[30] = '{1, 0, 2, ACC}; tbl[31] = '{1, 3, 3, ACC}; tbl[32] = '{1, 0, 3, ACC};
        tbl[33] = '{1, 4, 4, ACC};
        // 5x5 K=4 anti-diagonal for P2
        tbl[34] = '{1, 0, 0, ACC}; tbl[35] = '{1, 0, 4, ACC}; tbl[36] = '{1, 1, 0, ACC};
        tbl[37] = '{1, 1, 3, ACC}; tbl[38] = '{1, 3, 0, ACC}; tbl[39] = '{1, 2, 2, ACC};
        tbl[40] = '{1, 4, 1, ACC}; tbl[41] = '{1, 3, 1, ACC};

        rst = 1'b0;
        new_game = 1'b0;
        drive(0, 1'b1, 0, 0);
        drive(1, 1'b0, 0, 0);

        // reset held with move_valid high
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(NONE);
            step();
            check("rst_no_accept", 32'(acc_rej(0)), 32'(sbq.pop_front()));
        end
        check_state("rst", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        drive(0, 1'b0, 0, 0);
        step();
        check_state("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_state("post_rst_b", 1, 0, 0, 0, 0, 0, 0, 0, 1);

        play(0, 4);
        check_state("p1_row", 0, 9'h007, 9'h018, 5, 1, 1, 0, 0, 0);
        play(5, 5);
        check_state("over_ignore", 0, 9'h007, 9'h018, 5, 1, 1, 0, 0, 0);

        pulse_new_game();
        check_state("ng1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        play(6, 8);
        check_state("reject", 0, 9'h001, 0, 1, 1, 0, 0, 0, 1);

        pulse_new_game();
        play(9, 17);
        check_state("draw", 0, 9'h18D, 9'h072, 9, 1, 0, 0, 1, 0);

        pulse_new_game();
        play(18, 26);
        check_state("last_cell_win", 0, 9'h067, 9'h198, 9, 1, 1, 0, 0, 0);

        play(27, 32);
        check_state("n5_three_only", 1, 32'h41040, 32'hE, 6, 0, 0, 0, 0, 1);
        play(33, 33);
        check_state("n5_diag", 1, 32'h1041040, 32'hE, 7, 1, 1, 0, 0, 0);

        pulse_new_game();
        play(34, 41);
        check_state("n5_anti", 1, 32'h208021, 32'h11110, 8, 0, 0, 1, 0, 0);

        // new_game during the check cycle, with a move strobed at the same edge
        pulse_new_game();
        drive(0, 1'b1, 0, 0);
        sbq.push_back(ACC);
        step();
        check("ng_chk_first", 32'(acc_rej(0)), 32'(sbq.pop_front()));
        drive(0, 1'b1, 1, 1);
        new_game = 1'b1;
        sbq.push_back(NONE);
        step();
        check("ng_chk_no_accept", 32'(acc_rej(0)), 32'(sbq.pop_front()));
        new_game = 1'b0;
        drive(0, 1'b0, 0, 0);
        check_state("ng_chk", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        check_state("ng_chk_settled", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
